// File: rtl/axis_dram_fifo_bist_arbiter_if.sv
// AXI-Stream bundle shared by the ingress, DRAM-FIFO and egress ports of the
// DRAM FIFO BIST arbiter.
interface axis_dram_fifo_bist_arbiter_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tlast, output tvalid, input  tready);
  modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface

// File: rtl/axis_dram_fifo_bist_arbiter.sv
// Packet-atomic arbiter between user and BIST streams into one DRAM FIFO, with an
// order FIFO that routes each returning packet back to the source that sent it.
module axis_dram_fifo_bist_arbiter #(
  parameter int WIDTH        = 64,
  parameter int ORDER_AWIDTH = 5,
  parameter int CNT_W        = 32
) (
  input  logic                          bus_clk,
  input  logic                          bus_rst,
  input  logic                          clear,
  input  logic [1:0]                    mode,
  axis_dram_fifo_bist_arbiter_if.slave  usr_i,
  axis_dram_fifo_bist_arbiter_if.slave  bist_i,
  axis_dram_fifo_bist_arbiter_if.master fifo_o,
  axis_dram_fifo_bist_arbiter_if.slave  fifo_i,
  axis_dram_fifo_bist_arbiter_if.master usr_o,
  axis_dram_fifo_bist_arbiter_if.master bist_o,
  output logic [ORDER_AWIDTH:0]         inflight,
  output logic [31:0]                   usr_pkt_cnt,
  output logic [31:0]                   bist_pkt_cnt,
  output logic                          idle
);
  localparam int DEPTH = 1 << ORDER_AWIDTH;
  localparam logic [ORDER_AWIDTH:0] FULL_CNT = (ORDER_AWIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_USR, ST_BIST} state_t;

  state_t                r_state, w_state_nxt;
  logic [ORDER_AWIDTH:0] r_wr_ptr, r_rd_ptr;
  logic                  r_order [DEPTH];
  logic                  r_last_bist;
  logic [CNT_W-1:0]      r_usr_cnt, r_bist_cnt;

  logic w_full, w_empty, w_head;
  logic w_gnt_usr, w_gnt_bist, w_push, w_pop;
  logic w_usr_done, w_bist_done;

  assign inflight     = r_wr_ptr - r_rd_ptr;
  assign w_full       = (inflight == FULL_CNT);
  assign w_empty      = (r_wr_ptr == r_rd_ptr);
  assign w_head       = r_order[r_rd_ptr[ORDER_AWIDTH-1:0]];
  assign w_push       = w_gnt_usr | w_gnt_bist;
  assign idle         = (r_state == ST_IDLE) && w_empty;
  assign usr_pkt_cnt  = 32'(r_usr_cnt);
  assign bist_pkt_cnt = 32'(r_bist_cnt);

  // Grant decision; r_last_bist breaks round-robin ties toward the other source.
  always_comb begin
    w_gnt_usr  = 1'b0;
    w_gnt_bist = 1'b0;
    if (!clear && (r_state == ST_IDLE) && !w_full) begin
      case (mode)
        2'd1: w_gnt_bist = bist_i.tvalid;
        2'd2: begin
          if (usr_i.tvalid && bist_i.tvalid) begin
            w_gnt_usr  = r_last_bist;
            w_gnt_bist = !r_last_bist;
          end else begin
            w_gnt_usr  = usr_i.tvalid;
            w_gnt_bist = bist_i.tvalid;
          end
        end
        default: w_gnt_usr = usr_i.tvalid;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_usr_done    = 1'b0;
    w_bist_done   = 1'b0;
    fifo_o.tdata  = {WIDTH{1'b0}};
    fifo_o.tlast  = 1'b0;
    fifo_o.tvalid = 1'b0;
    usr_i.tready  = 1'b0;
    bist_i.tready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_usr)       w_state_nxt = ST_USR;
        else if (w_gnt_bist) w_state_nxt = ST_BIST;
      end
      ST_USR: begin
        if (!clear) begin
          fifo_o.tdata  = usr_i.tdata;
          fifo_o.tlast  = usr_i.tlast;
          fifo_o.tvalid = usr_i.tvalid;
          usr_i.tready  = fifo_o.tready;
          if (usr_i.tvalid && fifo_o.tready && usr_i.tlast) begin
            w_usr_done  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_BIST: begin
        if (!clear) begin
          fifo_o.tdata  = bist_i.tdata;
          fifo_o.tlast  = bist_i.tlast;
          fifo_o.tvalid = bist_i.tvalid;
          bist_i.tready = fifo_o.tready;
          if (bist_i.tvalid && fifo_o.tready && bist_i.tlast) begin
            w_bist_done = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Egress steering: the order-FIFO head owns the DRAM FIFO output until its tlast.
  always_comb begin
    usr_o.tdata   = {WIDTH{1'b0}};
    usr_o.tlast   = 1'b0;
    usr_o.tvalid  = 1'b0;
    bist_o.tdata  = {WIDTH{1'b0}};
    bist_o.tlast  = 1'b0;
    bist_o.tvalid = 1'b0;
    fifo_i.tready = 1'b0;
    w_pop         = 1'b0;
    if (!clear && !w_empty) begin
      if (w_head) begin
        bist_o.tdata  = fifo_i.tdata;
        bist_o.tlast  = fifo_i.tlast;
        bist_o.tvalid = fifo_i.tvalid;
        fifo_i.tready = bist_o.tready;
        w_pop         = fifo_i.tvalid && fifo_i.tlast && bist_o.tready;
      end else begin
        usr_o.tdata   = fifo_i.tdata;
        usr_o.tlast   = fifo_i.tlast;
        usr_o.tvalid  = fifo_i.tvalid;
        fifo_i.tready = usr_o.tready;
        w_pop         = fifo_i.tvalid && fifo_i.tlast && usr_o.tready;
      end
    end
  end

  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_last_bist <= 1'b1;
      r_usr_cnt   <= '0;
      r_bist_cnt  <= '0;
    end else if (clear) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_last_bist <= 1'b1;
      r_usr_cnt   <= '0;
      r_bist_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) begin
        r_wr_ptr    <= r_wr_ptr + 1'b1;
        r_last_bist <= w_gnt_bist;
      end
      if (w_pop)       r_rd_ptr   <= r_rd_ptr + 1'b1;
      if (w_usr_done)  r_usr_cnt  <= r_usr_cnt + 1'b1;
      if (w_bist_done) r_bist_cnt <= r_bist_cnt + 1'b1;
    end
  end

  // Order storage is plain data: only the pointers decide which entries are live.
  always_ff @(posedge bus_clk) begin
    if (w_push) r_order[r_wr_ptr[ORDER_AWIDTH-1:0]] <= w_gnt_bist;
  end
endmodule

// File: tb/tb_axis_dram_fifo_bist_arbiter.sv
// Directed bench for axis_dram_fifo_bist_arbiter: a queue-based behavioural model
// checked every cycle plus hand-computed expectations per scenario.
module tb_axis_dram_fifo_bist_arbiter;
  localparam int W = 64, OAW = 5, CW = 4, DEPTH = 32;

  logic clk = 1'b0;
  logic rst, clear;
  logic [1:0] mode;
  logic [OAW:0] inflight;
  logic [31:0] usr_pkt_cnt, bist_pkt_cnt;
  logic idle;

  always #5 clk = ~clk;

  axis_dram_fifo_bist_arbiter_if #(.WIDTH(W)) usr_i (), bist_i (), fifo_o (), fifo_i (), usr_o (), bist_o ();

  axis_dram_fifo_bist_arbiter #(.WIDTH(W), .ORDER_AWIDTH(OAW), .CNT_W(CW)) dut (
    .bus_clk(clk), .bus_rst(rst), .clear(clear), .mode(mode),
    .usr_i(usr_i), .bist_i(bist_i), .fifo_o(fifo_o), .fifo_i(fifo_i),
    .usr_o(usr_o), .bist_o(bist_o),
    .inflight(inflight), .usr_pkt_cnt(usr_pkt_cnt), .bist_pkt_cnt(bist_pkt_cnt), .idle(idle)
  );

  typedef struct packed { logic [63:0] d; logic l; } beat_t;
  beat_t uq[$], bq[$], dq[$], urx[$], brx[$];
  bit    ilog[$];
  bit    in_mid, bist_seen;
  bit    usr_en, bist_en, din_en, dout_en;
  int    u_acc;
  int    checks = 0, errors = 0;

  // Model state: ingress phase (0 idle, 1 user, 2 BIST), order queue, counters.
  int m_st, m_ucnt, m_bcnt;
  bit m_last;
  bit m_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input bit s, input int p, input int b);
    return {(s ? 8'hB0 : 8'hA0), 24'(p), 32'(b)};
  endfunction

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic do_clear();
    uq.delete(); bq.delete();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  // Stream drivers: sources, DRAM FIFO input acceptance and DRAM FIFO output.
  initial forever begin
    @(posedge clk); #1;
    usr_i.tvalid  = usr_en && (uq.size() != 0);
    usr_i.tdata   = (uq.size() != 0) ? uq[0].d : 64'd0;
    usr_i.tlast   = (uq.size() != 0) ? uq[0].l : 1'b0;
    bist_i.tvalid = bist_en && (bq.size() != 0);
    bist_i.tdata  = (bq.size() != 0) ? bq[0].d : 64'd0;
    bist_i.tlast  = (bq.size() != 0) ? bq[0].l : 1'b0;
    fifo_i.tvalid = dout_en && (dq.size() != 0);
    fifo_i.tdata  = (dq.size() != 0) ? dq[0].d : 64'd0;
    fifo_i.tlast  = (dq.size() != 0) ? dq[0].l : 1'b0;
    fifo_o.tready = din_en;
  end

  always @(negedge clk) begin : mon
    bit ne, head, e_urdy, e_brdy, e_fov, e_fir, e_uov, e_bov, pop;
    int g;
    if (rst) begin
      m_st = 0; m_q.delete(); m_ucnt = 0; m_bcnt = 0; m_last = 1'b1;
      dq.delete(); in_mid = 1'b0;
    end
    ne     = (m_q.size() != 0);
    head   = ne ? m_q[0] : 1'b0;
    e_urdy = !clear && (m_st == 1) && fifo_o.tready;
    e_brdy = !clear && (m_st == 2) && fifo_o.tready;
    e_fov  = !clear && (((m_st == 1) && usr_i.tvalid) || ((m_st == 2) && bist_i.tvalid));
    e_fir  = !clear && ne && (head ? bist_o.tready : usr_o.tready);
    e_uov  = !clear && ne && !head && fifo_i.tvalid;
    e_bov  = !clear && ne && head && fifo_i.tvalid;

    chk("usr_i_tready", usr_i.tready, e_urdy);
    chk("bist_i_tready", bist_i.tready, e_brdy);
    chk("fifo_o_tvalid", fifo_o.tvalid, e_fov);
    chk("fifo_i_tready", fifo_i.tready, e_fir);
    chk("usr_o_tvalid", usr_o.tvalid, e_uov);
    chk("bist_o_tvalid", bist_o.tvalid, e_bov);
    chk("inflight", inflight, m_q.size());
    chk("idle", idle, (m_st == 0) && !ne);
    chk("usr_pkt_cnt", usr_pkt_cnt, m_ucnt);
    chk("bist_pkt_cnt", bist_pkt_cnt, m_bcnt);
    if (e_fov) begin
      chk("fifo_o_tdata", fifo_o.tdata, (m_st == 1) ? usr_i.tdata : bist_i.tdata);
      chk("fifo_o_tlast", fifo_o.tlast, (m_st == 1) ? usr_i.tlast : bist_i.tlast);
    end
    if (e_uov) chk("usr_o_tdata", usr_o.tdata, fifo_i.tdata);
    if (e_bov) chk("bist_o_tdata", bist_o.tdata, fifo_i.tdata);

    // Environment reacts to the handshakes the DUT actually performed.
    if (bist_o.tvalid) bist_seen = 1'b1;
    if (usr_i.tvalid && usr_i.tready) begin void'(uq.pop_front()); u_acc++; end
    if (bist_i.tvalid && bist_i.tready) void'(bq.pop_front());
    if (fifo_i.tvalid && fifo_i.tready) void'(dq.pop_front());
    if (fifo_o.tvalid && fifo_o.tready) begin
      if (!in_mid) ilog.push_back(fifo_o.tdata[63:56] == 8'hB0);
      in_mid = !fifo_o.tlast;
      dq.push_back({fifo_o.tdata, fifo_o.tlast});
    end
    if (usr_o.tvalid && usr_o.tready) urx.push_back({usr_o.tdata, usr_o.tlast});
    if (bist_o.tvalid && bist_o.tready) brx.push_back({bist_o.tdata, bist_o.tlast});
    if (clear) begin dq.delete(); in_mid = 1'b0; end

    if (!rst) begin
      if (clear) begin
        m_st = 0; m_q.delete(); m_ucnt = 0; m_bcnt = 0; m_last = 1'b1;
      end else begin
        pop = e_fir && fifo_i.tvalid && fifo_i.tlast;
        g = 0;
        if ((m_st == 0) && (m_q.size() < DEPTH)) begin
          case (mode)
            2'd1: g = bist_i.tvalid ? 2 : 0;
            2'd2: begin
              if (usr_i.tvalid && bist_i.tvalid) g = m_last ? 1 : 2;
              else if (usr_i.tvalid) g = 1;
              else if (bist_i.tvalid) g = 2;
            end
            default: g = usr_i.tvalid ? 1 : 0;
          endcase
        end
        if ((m_st == 1) && e_urdy && usr_i.tvalid && usr_i.tlast) begin
          m_ucnt = (m_ucnt + 1) % (1 << CW); m_st = 0;
        end else if ((m_st == 2) && e_brdy && bist_i.tvalid && bist_i.tlast) begin
          m_bcnt = (m_bcnt + 1) % (1 << CW); m_st = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (g != 0) begin
          m_q.push_back(g == 2); m_st = g; m_last = (g == 2);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bit exp_order [8];
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
    rst = 1'b1; clear = 1'b0; mode = 2'd0;
    usr_en = 1'b1; bist_en = 1'b1; din_en = 1'b1; dout_en = 1'b1;
    usr_i.tvalid = 0; usr_i.tdata = 0; usr_i.tlast = 0;
    bist_i.tvalid = 0; bist_i.tdata = 0; bist_i.tlast = 0;
    fifo_i.tvalid = 0; fifo_i.tdata = 0; fifo_i.tlast = 0;
    fifo_o.tready = 0; usr_o.tready = 0; bist_o.tready = 0;
    repeat (3) cyc();
    chk("rst_inflight", inflight, 0);
    chk("rst_idle", idle, 1);
    chk("rst_usr_tready", usr_i.tready, 0);
    chk("rst_fifo_i_tready", fifo_i.tready, 0);
    rst = 1'b0;
    cyc();

    // Mode 0: 16-beat ramp held at the user egress, then released.
    bist_seen = 1'b0;
    for (int i = 0; i < 16; i++) uq.push_back({mk(0, 0, i), (i == 15)});
    for (int i = 0; i < 200 && usr_pkt_cnt != 1; i++) cyc();
    chk("t1_usr_cnt", usr_pkt_cnt, 1);
    repeat (5) cyc();
    chk("t1_inflight_held", inflight, 1);
    chk("t1_rx_held", urx.size(), 0);
    usr_o.tready = 1'b1;
    for (int i = 0; i < 200 && urx.size() < 16; i++) cyc();
    chk("t1_rx_cnt", urx.size(), 16);
    for (int i = 0; i < 16 && i < urx.size(); i++) begin
      chk("t1_rx_data", urx[i].d, mk(0, 0, i));
      chk("t1_rx_last", urx[i].l, (i == 15));
    end
    repeat (3) cyc();
    chk("t1_inflight_end", inflight, 0);
    chk("t1_idle_end", idle, 1);
    chk("t1_bist_never", bist_seen, 0);

    // Mode 2: four 5-beat packets per source offered continuously.
    do_clear();
    chk("t2_cnt_cleared", usr_pkt_cnt, 0);
    mode = 2'd2; usr_o.tready = 1'b1; bist_o.tready = 1'b1;
    ilog.delete(); urx.delete(); brx.delete();
    for (int p = 0; p < 4; p++)
      for (int b = 0; b < 5; b++) begin
        uq.push_back({mk(0, p, b), (b == 4)});
        bq.push_back({mk(1, p, b), (b == 4)});
      end
    for (int i = 0; i < 500 && (urx.size() < 20 || brx.size() < 20); i++) cyc();
    chk("t2_order_len", ilog.size(), 8);
    for (int k = 0; k < 8 && k < ilog.size(); k++) chk("t2_order", ilog[k], exp_order[k]);
    chk("t2_urx_len", urx.size(), 20);
    chk("t2_brx_len", brx.size(), 20);
    for (int k = 0; k < 20 && k < urx.size(); k++) chk("t2_urx", urx[k].d, mk(0, k / 5, k % 5));
    for (int k = 0; k < 20 && k < brx.size(); k++) chk("t2_brx", brx[k].d, mk(1, k / 5, k % 5));
    chk("t2_usr_cnt", usr_pkt_cnt, 4);
    chk("t2_bist_cnt", bist_pkt_cnt, 4);

    // Order FIFO full: egress blocked, 40 single-beat packets offered.
    do_clear();
    mode = 2'd0; usr_o.tready = 1'b0; ilog.delete(); urx.delete();
    for (int p = 0; p < 40; p++) uq.push_back({mk(0, p, 0), 1'b1});
    repeat (150) cyc();
    chk("t3_inflight_full", inflight, 32);
    chk("t3_grants", ilog.size(), 32);
    chk("t3_left", uq.size(), 8);
    usr_o.tready = 1'b1;
    cyc();
    usr_o.tready = 1'b0;
    chk("t3_inflight_pop", inflight, 31);
    chk("t3_grants_pop", ilog.size(), 32);
    repeat (2) cyc();
    chk("t3_inflight_refill", inflight, 32);
    chk("t3_grants_refill", ilog.size(), 33);
    chk("t3_urx", urx.size(), 1);

    // Mode switch 0 -> 1 inside an 8-beat user packet.
    do_clear();
    mode = 2'd0; usr_o.tready = 1'b1; bist_o.tready = 1'b1;
    ilog.delete(); urx.delete(); brx.delete(); u_acc = 0;
    for (int b = 0; b < 8; b++) uq.push_back({mk(0, 0, b), (b == 7)});
    for (int b = 0; b < 4; b++) uq.push_back({mk(0, 1, b), (b == 3)});
    for (int b = 0; b < 2; b++) bq.push_back({mk(1, 0, b), (b == 1)});
    for (int i = 0; i < 100 && u_acc < 3; i++) cyc();
    mode = 2'd1;
    for (int i = 0; i < 100 && bist_pkt_cnt != 1; i++) cyc();
    repeat (10) cyc();
    chk("t4_grants", ilog.size(), 2);
    if (ilog.size() >= 2) begin
      chk("t4_first_usr", ilog[0], 0);
      chk("t4_then_bist", ilog[1], 1);
    end
    chk("t4_usr_cnt", usr_pkt_cnt, 1);
    chk("t4_bist_cnt", bist_pkt_cnt, 1);
    chk("t4_usr_blocked", uq.size(), 4);
    chk("t4_urx", urx.size(), 8);
    chk("t4_brx", brx.size(), 2);

    // Clear with three packets in flight.
    do_clear();
    mode = 2'd0; usr_o.tready = 1'b0;
    for (int p = 0; p < 3; p++) uq.push_back({mk(0, p, 0), 1'b1});
    for (int i = 0; i < 100 && inflight != 3; i++) cyc();
    repeat (2) cyc();
    chk("t5_inflight_pre", inflight, 3);
    chk("t5_cnt_pre", usr_pkt_cnt, 3);
    uq.push_back({mk(0, 9, 0), 1'b1});
    clear = 1'b1; usr_o.tready = 1'b1;
    #1;
    chk("t5_fifo_i_tready_clr", fifo_i.tready, 0);
    chk("t5_usr_o_tvalid_clr", usr_o.tvalid, 0);
    cyc();
    clear = 1'b0;
    chk("t5_inflight_post", inflight, 0);
    chk("t5_cnt_post", usr_pkt_cnt, 0);
    chk("t5_idle_post", idle, 1);
    for (int i = 0; i < 100 && usr_pkt_cnt != 1; i++) cyc();
    chk("t5_resume", usr_pkt_cnt, 1);

    // Counter wrap with a 4-bit counter: 15 -> 0.
    do_clear();
    mode = 2'd0; usr_o.tready = 1'b1;
    for (int p = 0; p < 15; p++) uq.push_back({mk(0, p, 0), 1'b1});
    for (int i = 0; i < 200 && uq.size() != 0; i++) cyc();
    repeat (4) cyc();
    chk("t6_cnt_15", usr_pkt_cnt, 15);
    uq.push_back({mk(0, 15, 0), 1'b1});
    repeat (8) cyc();
    chk("t6_cnt_wrap", usr_pkt_cnt, 0);
    chk("t6_bist_cnt", bist_pkt_cnt, 0);
    chk("t6_inflight", inflight, 0);
    chk("t6_idle", idle, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
